// File: rtl/croc_pkg.sv
// Shared types and defaults for the croc SoC user-domain OBI plumbing.
package croc_pkg;

    localparam int unsigned UserNumMgr   = 2;
    localparam int unsigned UserMaxTrans = 2;

    // Round-robin index wide enough to name any user-domain manager
    typedef logic [$clog2(UserNumMgr)-1:0] user_rr_idx_t;

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of granted manager IDs, used to steer OBI responses back to their requester.
module obi_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/user_obi_arbiter.sv
// Round-robin arbiter sharing the user-domain OBI manager port among several user managers,
// with in-order response routing through an ID FIFO.
module user_obi_arbiter
    import croc_pkg::*;
#(
    parameter int unsigned NumMgr    = UserNumMgr,
    parameter int unsigned MaxTrans  = UserMaxTrans,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumMgr-1:0]                      in_req_i,
    input  logic [NumMgr-1:0]                      in_we_i,
    input  logic [NumMgr-1:0][DataWidth/8-1:0]     in_be_i,
    input  logic [NumMgr-1:0][AddrWidth-1:0]       in_addr_i,
    input  logic [NumMgr-1:0][DataWidth-1:0]       in_wdata_i,
    output logic [NumMgr-1:0]                      in_gnt_o,
    output logic [NumMgr-1:0]                      in_rvalid_o,
    output logic [NumMgr-1:0]                      in_err_o,
    output logic [NumMgr-1:0][DataWidth-1:0]       in_rdata_o,
    output logic                                   out_req_o,
    output logic                                   out_we_o,
    output logic [DataWidth/8-1:0]                 out_be_o,
    output logic [AddrWidth-1:0]                   out_addr_o,
    output logic [DataWidth-1:0]                   out_wdata_o,
    input  logic                                   out_gnt_i,
    input  logic                                   out_rvalid_i,
    input  logic                                   out_err_i,
    input  logic [DataWidth-1:0]                   out_rdata_i,
    output logic                                   spurious_o
);

    localparam int unsigned IdxW = $clog2(NumMgr);
    typedef logic [IdxW-1:0] idx_t;

    idx_t rr_q;
    idx_t lock_idx_q;
    logic lock_q;
    logic spurious_q;
    idx_t arb_idx;
    idx_t sel_idx;
    idx_t head_idx;
    logic fifo_full;
    logic fifo_empty;
    logic grant;
    logic resp_valid;

    // First requester at or after the priority pointer, wrapping around
    always_comb begin
        logic found;
        idx_t cand;
        arb_idx = rr_q;
        found   = 1'b0;
        for (int i = 0; i < int'(NumMgr); i++) begin
            cand = idx_t'((int'(rr_q) + i) % int'(NumMgr));
            if (!found && in_req_i[cand]) begin
                arb_idx = cand;
                found   = 1'b1;
            end
        end
    end

    assign sel_idx     = lock_q ? lock_idx_q : arb_idx;
    assign out_req_o   = !rst_i && (|in_req_i) && !fifo_full;
    assign grant       = out_req_o && out_gnt_i;
    assign out_we_o    = in_we_i[sel_idx];
    assign out_be_o    = in_be_i[sel_idx];
    assign out_addr_o  = in_addr_i[sel_idx];
    assign out_wdata_o = in_wdata_i[sel_idx];

    assign resp_valid  = !rst_i && out_rvalid_i && !fifo_empty;
    assign spurious_o  = spurious_q;

    always_comb begin
        in_gnt_o    = '0;
        in_rvalid_o = '0;
        in_err_o    = '0;
        for (int k = 0; k < int'(NumMgr); k++) begin
            in_rdata_o[k]  = out_rdata_i;
            in_gnt_o[k]    = grant && (sel_idx == idx_t'(k));
            in_rvalid_o[k] = resp_valid && (head_idx == idx_t'(k));
            in_err_o[k]    = resp_valid && out_err_i && (head_idx == idx_t'(k));
        end
    end

    // The lock freezes the payload from the first ungranted request cycle until the grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (grant) begin
                lock_q <= 1'b0;
                rr_q   <= (sel_idx == idx_t'(NumMgr - 1)) ? '0 : sel_idx + idx_t'(1);
            end else if (out_req_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel_idx;
            end
            if (out_rvalid_i && fifo_empty) begin
                spurious_q <= 1'b1;
            end
        end
    end

    obi_id_fifo #(
        .Depth (MaxTrans),
        .Width (IdxW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .data_i  (sel_idx),
        .pop_i   (resp_valid),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    locked_req_held : assert property (@(posedge clk_i) disable iff (rst_i)
        lock_q |-> in_req_i[lock_idx_q]);

endmodule

// File: tb/tb_user_obi_arbiter.sv
// Directed bench for user_obi_arbiter with two managers and two outstanding transactions.
module tb_user_obi_arbiter;

    localparam int unsigned NumMgr    = 2;
    localparam int unsigned MaxTrans  = 2;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;

    logic                               clk_i = 1'b0;
    logic                               rst_i;
    logic [NumMgr-1:0]                  in_req_i;
    logic [NumMgr-1:0]                  in_we_i;
    logic [NumMgr-1:0][DataWidth/8-1:0] in_be_i;
    logic [NumMgr-1:0][AddrWidth-1:0]   in_addr_i;
    logic [NumMgr-1:0][DataWidth-1:0]   in_wdata_i;
    logic [NumMgr-1:0]                  in_gnt_o;
    logic [NumMgr-1:0]                  in_rvalid_o;
    logic [NumMgr-1:0]                  in_err_o;
    logic [NumMgr-1:0][DataWidth-1:0]   in_rdata_o;
    logic                               out_req_o;
    logic                               out_we_o;
    logic [DataWidth/8-1:0]             out_be_o;
    logic [AddrWidth-1:0]               out_addr_o;
    logic [DataWidth-1:0]               out_wdata_o;
    logic                               out_gnt_i;
    logic                               out_rvalid_i;
    logic                               out_err_i;
    logic [DataWidth-1:0]               out_rdata_i;
    logic                               spurious_o;

    int vectors     = 0;
    int miscompares = 0;

    user_obi_arbiter #(
        .NumMgr    (NumMgr),
        .MaxTrans  (MaxTrans),
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_req_i     (in_req_i),
        .in_we_i      (in_we_i),
        .in_be_i      (in_be_i),
        .in_addr_i    (in_addr_i),
        .in_wdata_i   (in_wdata_i),
        .in_gnt_o     (in_gnt_o),
        .in_rvalid_o  (in_rvalid_o),
        .in_err_o     (in_err_o),
        .in_rdata_o   (in_rdata_o),
        .out_req_o    (out_req_o),
        .out_we_o     (out_we_o),
        .out_be_o     (out_be_o),
        .out_addr_o   (out_addr_o),
        .out_wdata_o  (out_wdata_o),
        .out_gnt_i    (out_gnt_i),
        .out_rvalid_i (out_rvalid_i),
        .out_err_i    (out_err_i),
        .out_rdata_i  (out_rdata_i),
        .spurious_o   (spurious_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; in_req_i = 2'b11; out_gnt_i = 1'b1; out_rvalid_i = 1'b1;
        #1;
        vectors++; if (out_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_req: got %b exp 0", out_req_o); end
        vectors++; if (in_gnt_o !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_gnt: got %b exp 00", in_gnt_o); end
        vectors++; if (in_rvalid_o !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_rvalid: got %b exp 00", in_rvalid_o); end
        tick(); tick();
        vectors++; if (spurious_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_spurious: got %b exp 0", spurious_o); end
        rst_i = 1'b0; in_req_i = 2'b00; out_gnt_i = 1'b0; out_rvalid_i = 1'b0;
        #1;
        vectors++; if (out_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_out_req: got %b exp 0", out_req_o); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt [4];
        logic [1:0] exp_rv  [4];
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_rv  = '{2'b00, 2'b01, 2'b10, 2'b01};
        in_req_i = 2'b11; out_gnt_i = 1'b1; out_rdata_i = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            out_rvalid_i = (c != 0);
            #1;
            vectors++; if (in_gnt_o !== exp_gnt[c]) begin miscompares++; $display("[TB] FAIL rr_gnt%0d: got %b exp %b", c, in_gnt_o, exp_gnt[c]); end
            vectors++; if (in_rvalid_o !== exp_rv[c]) begin miscompares++; $display("[TB] FAIL rr_rvalid%0d: got %b exp %b", c, in_rvalid_o, exp_rv[c]); end
            tick();
        end
        in_req_i = 2'b00; out_gnt_i = 1'b0; out_rvalid_i = 1'b1;
        #1;
        vectors++; if (in_rvalid_o !== 2'b10) begin miscompares++; $display("[TB] FAIL rr_drain: got %b exp 10", in_rvalid_o); end
        vectors++; if (in_rdata_o !== {2{32'h1234_5678}}) begin miscompares++; $display("[TB] FAIL rr_rdata_bcast: got %h exp %h", in_rdata_o, {2{32'h1234_5678}}); end
        tick();
        out_rvalid_i = 1'b0;
    endtask

    task automatic test_lock();
        in_req_i = 2'b10; out_gnt_i = 1'b0;
        #1;
        vectors++; if (out_req_o !== 1'b1) begin miscompares++; $display("[TB] FAIL lock_req: got %b exp 1", out_req_o); end
        vectors++; if (out_addr_o !== 32'h2000_0010) begin miscompares++; $display("[TB] FAIL lock_addr_c1: got %h exp 20000010", out_addr_o); end
        vectors++; if (out_wdata_o !== 32'hCAFE_0001) begin miscompares++; $display("[TB] FAIL lock_wdata: got %h exp cafe0001", out_wdata_o); end
        vectors++; if ({out_we_o, out_be_o} !== 5'b1_0011) begin miscompares++; $display("[TB] FAIL lock_we_be: got %b exp 10011", {out_we_o, out_be_o}); end
        tick();
        in_req_i = 2'b11;
        for (int c = 2; c <= 3; c++) begin
            #1;
            vectors++; if (out_addr_o !== 32'h2000_0010) begin miscompares++; $display("[TB] FAIL lock_addr_c%0d: got %h exp 20000010", c, out_addr_o); end
            vectors++; if (in_gnt_o !== 2'b00) begin miscompares++; $display("[TB] FAIL lock_nognt_c%0d: got %b exp 00", c, in_gnt_o); end
            tick();
        end
        out_gnt_i = 1'b1;
        #1;
        vectors++; if (in_gnt_o !== 2'b10) begin miscompares++; $display("[TB] FAIL lock_gnt1: got %b exp 10", in_gnt_o); end
        vectors++; if (out_addr_o !== 32'h2000_0010) begin miscompares++; $display("[TB] FAIL lock_addr_gnt: got %h exp 20000010", out_addr_o); end
        tick();
        in_req_i = 2'b01;
        #1;
        vectors++; if (in_gnt_o !== 2'b01) begin miscompares++; $display("[TB] FAIL lock_gnt0: got %b exp 01", in_gnt_o); end
        vectors++; if (out_addr_o !== 32'h1000_0000) begin miscompares++; $display("[TB] FAIL lock_addr_mgr0: got %h exp 10000000", out_addr_o); end
        tick();
        in_req_i = 2'b00; out_gnt_i = 1'b0; out_rvalid_i = 1'b1;
        #1;
        vectors++; if (in_rvalid_o !== 2'b10) begin miscompares++; $display("[TB] FAIL lock_resp1: got %b exp 10", in_rvalid_o); end
        tick();
        #1;
        vectors++; if (in_rvalid_o !== 2'b01) begin miscompares++; $display("[TB] FAIL lock_resp0: got %b exp 01", in_rvalid_o); end
        tick();
        out_rvalid_i = 1'b0;
    endtask

    task automatic test_full();
        in_req_i = 2'b01; out_gnt_i = 1'b1;
        tick();
        in_req_i = 2'b10;
        tick();
        in_req_i = 2'b11;
        #1;
        vectors++; if (out_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL full_req: got %b exp 0", out_req_o); end
        vectors++; if (in_gnt_o !== 2'b00) begin miscompares++; $display("[TB] FAIL full_gnt: got %b exp 00", in_gnt_o); end
        tick();
        out_rvalid_i = 1'b1;
        #1;
        vectors++; if (out_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL full_pop_req: got %b exp 0", out_req_o); end
        vectors++; if (in_rvalid_o !== 2'b01) begin miscompares++; $display("[TB] FAIL full_pop_rvalid: got %b exp 01", in_rvalid_o); end
        tick();
        out_rvalid_i = 1'b0;
        #1;
        vectors++; if (in_gnt_o !== 2'b01) begin miscompares++; $display("[TB] FAIL full_regrant: got %b exp 01", in_gnt_o); end
        tick();
        in_req_i = 2'b00; out_gnt_i = 1'b0; out_rvalid_i = 1'b1;
        #1;
        vectors++; if (in_rvalid_o !== 2'b10) begin miscompares++; $display("[TB] FAIL full_drain1: got %b exp 10", in_rvalid_o); end
        tick();
        #1;
        vectors++; if (in_rvalid_o !== 2'b01) begin miscompares++; $display("[TB] FAIL full_drain0: got %b exp 01", in_rvalid_o); end
        tick();
        out_rvalid_i = 1'b0;
    endtask

    task automatic test_response_order();
        in_req_i = 2'b10; out_gnt_i = 1'b1;
        tick();
        in_req_i = 2'b01;
        tick();
        in_req_i = 2'b00; out_gnt_i = 1'b0;
        out_rvalid_i = 1'b1; out_rdata_i = 32'hAAAA_0001; out_err_i = 1'b0;
        #1;
        vectors++; if (in_rvalid_o !== 2'b10) begin miscompares++; $display("[TB] FAIL resp_first_rvalid: got %b exp 10", in_rvalid_o); end
        vectors++; if (in_rdata_o[1] !== 32'hAAAA_0001) begin miscompares++; $display("[TB] FAIL resp_first_rdata: got %h exp aaaa0001", in_rdata_o[1]); end
        vectors++; if (in_err_o !== 2'b00) begin miscompares++; $display("[TB] FAIL resp_first_err: got %b exp 00", in_err_o); end
        tick();
        out_rdata_i = 32'hBBBB_0002; out_err_i = 1'b1;
        #1;
        vectors++; if (in_rvalid_o !== 2'b01) begin miscompares++; $display("[TB] FAIL resp_second_rvalid: got %b exp 01", in_rvalid_o); end
        vectors++; if (in_rdata_o[0] !== 32'hBBBB_0002) begin miscompares++; $display("[TB] FAIL resp_second_rdata: got %h exp bbbb0002", in_rdata_o[0]); end
        vectors++; if (in_err_o !== 2'b01) begin miscompares++; $display("[TB] FAIL resp_second_err: got %b exp 01", in_err_o); end
        tick();
        out_rvalid_i = 1'b0; out_err_i = 1'b0;
        #1;
        vectors++; if (spurious_o !== 1'b0) begin miscompares++; $display("[TB] FAIL resp_no_spurious: got %b exp 0", spurious_o); end
    endtask

    task automatic test_spurious();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; out_rvalid_i = 1'b1;
        #1;
        vectors++; if (in_rvalid_o !== 2'b00) begin miscompares++; $display("[TB] FAIL spur_rvalid: got %b exp 00", in_rvalid_o); end
        vectors++; if (spurious_o !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_early: got %b exp 0", spurious_o); end
        tick();
        out_rvalid_i = 1'b0;
        #1;
        vectors++; if (spurious_o !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_set: got %b exp 1", spurious_o); end
        tick(); tick();
        vectors++; if (spurious_o !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_held: got %b exp 1", spurious_o); end
    endtask

    task automatic test_reset_in_flight();
        in_req_i = 2'b01; out_gnt_i = 1'b1;
        #1;
        vectors++; if (in_gnt_o !== 2'b01) begin miscompares++; $display("[TB] FAIL rif_pre_gnt: got %b exp 01", in_gnt_o); end
        tick();
        rst_i = 1'b1; in_req_i = 2'b11;
        #1;
        vectors++; if (out_req_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rif_rst_req: got %b exp 0", out_req_o); end
        vectors++; if (in_gnt_o !== 2'b00) begin miscompares++; $display("[TB] FAIL rif_rst_gnt: got %b exp 00", in_gnt_o); end
        tick();
        rst_i = 1'b0;
        #1;
        vectors++; if (in_gnt_o !== 2'b01) begin miscompares++; $display("[TB] FAIL rif_post_gnt: got %b exp 01", in_gnt_o); end
        vectors++; if (spurious_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rif_spur_clr: got %b exp 0", spurious_o); end
        tick();
        in_req_i = 2'b00; out_gnt_i = 1'b0; out_rvalid_i = 1'b1;
        #1;
        vectors++; if (in_rvalid_o !== 2'b01) begin miscompares++; $display("[TB] FAIL rif_new_resp: got %b exp 01", in_rvalid_o); end
        tick();
        #1;
        vectors++; if (in_rvalid_o !== 2'b00) begin miscompares++; $display("[TB] FAIL rif_stale_resp: got %b exp 00", in_rvalid_o); end
        tick();
        out_rvalid_i = 1'b0;
        #1;
        vectors++; if (spurious_o !== 1'b1) begin miscompares++; $display("[TB] FAIL rif_stale_spur: got %b exp 1", spurious_o); end
        tick();
    endtask

    initial begin
        rst_i = 1'b1; in_req_i = '0; in_we_i = 2'b10;
        in_be_i[0] = 4'hF;             in_be_i[1] = 4'h3;
        in_addr_i[0] = 32'h1000_0000;  in_addr_i[1] = 32'h2000_0010;
        in_wdata_i[0] = 32'h0000_00A0; in_wdata_i[1] = 32'hCAFE_0001;
        out_gnt_i = 1'b0; out_rvalid_i = 1'b0; out_err_i = 1'b0; out_rdata_i = '0;
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_response_order();
        test_spurious();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/user_obi_arbiter.md
USER_OBI_ARBITER -- requirements
Module: user_obi_arbiter

Interface
REQ-001 SHALL have parameter NumMgr, default 2, number of user-domain OBI managers sharing the user manager port (range 2..8).
REQ-002 SHALL have parameter MaxTrans, default 2, maximum outstanding granted-but-unresponded transactions (range 1..8).
REQ-003 SHALL have parameter AddrWidth, default 32, OBI address width; DataWidth, default 32, OBI data width.
REQ-004 SHALL have the following ports: clk_i  in  1  sole clock; reset is synchronous, active-high.
REQ-005 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have ports in_req_i / in_we_i  in  NumMgr  per-manager request and write-enable.
REQ-007 SHALL have ports in_be_i  in  NumMgr x DataWidth/8; in_addr_i  in  NumMgr x AddrWidth; in_wdata_i  in  NumMgr x DataWidth.
REQ-008 SHALL have ports in_gnt_o / in_rvalid_o / in_err_o  out  NumMgr; in_rdata_o  out  NumMgr x DataWidth.
REQ-009 SHALL have ports out_req_o, out_we_o  out  1; out_be_o, out_addr_o, out_wdata_o  out  matching widths.
REQ-010 SHALL have ports out_gnt_i, out_rvalid_i, out_err_i  in  1; out_rdata_i  in  DataWidth.
REQ-011 SHALL have port spurious_o  out  1  sticky flag: out_rvalid_i arrived with nothing outstanding.

Function
REQ-012 SHALL arbitrate round-robin: the priority pointer rr_q names the highest-priority manager; the first requesting index at or after rr_q, wrapping, is selected.
REQ-013 SHALL drive out_req_o=1 when any in_req_i is high and fewer than MaxTrans transactions are outstanding; out_we/be/addr/wdata SHALL mux from the selected manager.
REQ-014 SHALL hold the selection fixed from the first cycle out_req_o=1 without out_gnt_i until the grant (lock register), so the request payload stays stable per OBI.
REQ-015 SHALL assert in_gnt_o[k] combinationally exactly when out_req_o=1, out_gnt_i=1 and k is selected; all other in_gnt_o bits SHALL be 0.
REQ-016 SHALL, on each grant to k, push k into an in-order ID FIFO and set rr_q=(k+1) mod NumMgr next cycle.
REQ-017 SHALL route out_rvalid_i, out_rdata_i and out_err_i to the manager at the FIFO head in the same cycle (zero added response latency), then pop.
REQ-018 SHALL drive in_rdata_o to all managers from out_rdata_i; only in_rvalid_o/in_err_o are per-manager gated.
REQ-019 SHALL block new requests while the FIFO holds MaxTrans entries, even if a response pops in the same cycle (no push/pop bypass when full).
REQ-020 SHALL support push and pop in the same cycle when not full; occupancy is then unchanged.
REQ-021 SHALL, on out_rvalid_i with an empty FIFO, drive no in_rvalid_o, leave the FIFO unchanged, and set spurious_o until reset.
REQ-022 SHALL keep the lock if the locked manager drops in_req_i before grant; this is a protocol violation and is flagged by an assertion, not repaired.

Reset
REQ-023 SHALL, when rst_i=1 at a clock edge, clear the FIFO, set rr_q=0, clear the lock and spurious_o.
REQ-024 SHALL drive out_req_o=0 and all in_gnt_o/in_rvalid_o/in_err_o=0 during any cycle rst_i=1, regardless of inputs.
REQ-025 SHALL discard responses in flight at reset; a subsequent unmatched out_rvalid_i sets spurious_o.

Structure
REQ-026 SHALL place the round-robin index typedef (clog2(NumMgr) bits) and default MaxTrans constant in croc_pkg.
REQ-027 SHALL implement the ID FIFO as one sub-module, obi_id_fifo (depth MaxTrans, width clog2(NumMgr), synchronous active-high reset, full/empty/push/pop).
REQ-028 SHALL sit in user_domain between the user managers and the user manager OBI port of croc_domain.

Verification
REQ-029 SHALL cover: mgr0 and mgr1 request continuously, out_gnt_i=1 always -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-030 SHALL cover: mgr1 requests addr 0x2000_0010, out_gnt_i held 0 for 3 cycles, mgr0 raises request on cycle 2 -> out_addr_o stays 0x2000_0010 until grant to 1.
REQ-031 SHALL cover: MaxTrans=2, two grants, no response -> out_req_o=0; response with out_rvalid_i and new request in same cycle -> grant only next cycle.
REQ-032 SHALL cover: grants to 1 then 0, responses rdata 0xAAAA_0001 then 0xBBBB_0002 -> in_rvalid_o[1] with first, in_rvalid_o[0] with second.
REQ-033 SHALL cover: out_rvalid_i=1 after reset with nothing granted -> no in_rvalid_o, spurious_o=1 next cycle and held.
REQ-034 SHALL cover: rst_i pulsed with one transaction outstanding -> FIFO empty, rr_q=0, next grant to manager 0 when both request.
